// File: rtl/i2s_tx_10xe_aud_frame_buf.sv
// ---------------------------------------------------------------------------
// i2s_tx_10xe_aud_frame_buf
//
// Audio frame assembler and frame FIFO sitting in front of the I2S TX
// serializer. Per-channel AXI-Stream beats are checked for channel order
// (TID), assembled into complete frames, and only complete frames are
// queued. The serializer pops one frame per frame_req cycle; the frame
// appears on frame_data with frame_valid one cycle later.
//
// Ports
//   s_axis_aud_aclk     : single clock for the whole block
//   s_axis_aud_aresetn  : asynchronous active-low reset
//   core_en             : core enable; low flushes the FIFO and the assembler
//   flag_clr            : one-cycle pulse clearing both sticky flags
//   s_axis_aud_tdata    : audio beat, sample at [SAMPLE_LSB +: SAMPLE_W]
//   s_axis_aud_tid      : channel number of the beat
//   s_axis_aud_tvalid   : beat valid
//   s_axis_aud_tready   : core_en & !fifo_full
//   frame_req           : serializer frame request, one pop per high cycle
//   frame_data          : channel k at [k*SAMPLE_W +: SAMPLE_W]
//   frame_valid         : popped frame valid, one cycle after frame_req
//   fifo_empty          : no complete frame stored
//   fifo_full           : DEPTH frames stored
//   underflow_flag      : sticky, frame_req while enabled and empty
//   seq_err_flag        : sticky, TID out of order or out of range
//   fifo_level          : registered frame count (only with
//                         I2S_TX_10XE_FIFO_LEVEL_EN defined)
//
// Optional feature macro: I2S_TX_10XE_FIFO_LEVEL_EN
// ---------------------------------------------------------------------------
module i2s_tx_10xe_aud_frame_buf #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 24,
  parameter int SAMPLE_LSB = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         s_axis_aud_aclk,
  input  logic                         s_axis_aud_aresetn,
  input  logic                         core_en,
  input  logic                         flag_clr,
  input  logic [31:0]                  s_axis_aud_tdata,
  input  logic [2:0]                   s_axis_aud_tid,
  input  logic                         s_axis_aud_tvalid,
  output logic                         s_axis_aud_tready,
  input  logic                         frame_req,
  output logic [NUM_CH*SAMPLE_W-1:0]   frame_data,
  output logic                         frame_valid,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic                         underflow_flag,
  output logic                         seq_err_flag
`ifdef I2S_TX_10XE_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
`endif
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0]    LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Channel the assembler expects next (0..NUM_CH-1).
  logic [2:0]    exp_ch_q, exp_ch_d;
  logic [FW-1:0] staging_q, staging_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] frame_data_q, frame_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic          underflow_q, underflow_d;
  logic          seq_err_q, seq_err_d;

  logic [FW-1:0] mem_q [DEPTH];

  logic                accept;
  logic                push;
  logic                pop_req;
  logic                pop_ok;
  logic                uf_set;
  logic                seq_set;
  logic [SAMPLE_W-1:0] sample;

  // Only the sample field of tdata is meaningful; fold the rest away.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_aud_tdata;

  assign fifo_empty        = (count_q == '0);
  assign fifo_full         = (count_q == DEPTH_CNT);
  assign s_axis_aud_tready = core_en & ~fifo_full;
  assign accept            = s_axis_aud_tvalid & s_axis_aud_tready;
  assign sample            = s_axis_aud_tdata[SAMPLE_LSB +: SAMPLE_W];

  assign frame_data     = frame_data_q;
  assign frame_valid    = frame_valid_q;
  assign underflow_flag = underflow_q;
  assign seq_err_flag   = seq_err_q;

`ifdef I2S_TX_10XE_FIFO_LEVEL_EN
  assign fifo_level = count_q;
`endif

  // ------------------------------------------------------------------------
  // Frame assembly: order check on TID and staging of the current frame.
  // ------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    exp_ch_d  = exp_ch_q;
    staging_d = staging_q;
    push      = 1'b0;
    seq_set   = 1'b0;

    if (!core_en) begin
      exp_ch_d = '0;
    end else if (accept) begin
      if (s_axis_aud_tid == exp_ch_q) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (exp_ch_q == 3'(k)) staging_d[k*SAMPLE_W +: SAMPLE_W] = sample;
        end
        if (s_axis_aud_tid == LAST_CH) begin
          // staging_d already holds the final sample, so it is the frame.
          push     = 1'b1;
          exp_ch_d = '0;
        end else begin
          exp_ch_d = exp_ch_q + 3'd1;
        end
      end else if (s_axis_aud_tid == 3'd0) begin
        // A channel-0 beat out of turn restarts the frame.
        seq_set                   = 1'b1;
        staging_d[SAMPLE_W-1:0]   = sample;
        exp_ch_d                  = 3'd1;
      end else begin
        seq_set  = 1'b1;
        exp_ch_d = '0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Frame FIFO bookkeeping, pop path and sticky flags.
  // ------------------------------------------------------------------------
  always_comb begin
    pop_req       = frame_req & core_en;
    pop_ok        = pop_req & ~fifo_empty;
    // No bypass: a push in the same cycle does not rescue an empty pop.
    uf_set        = pop_req & fifo_empty;

    count_d       = count_q + CW'(push) - CW'(pop_ok);
    wr_ptr_d      = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    frame_valid_d = pop_ok;
    frame_data_d  = frame_data_q;

    if (!core_en) begin
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      frame_data_d = '0;
    end else if (pop_ok) begin
      frame_data_d = mem_q[rd_ptr_q];
    end else if (pop_req) begin
      frame_data_d = '0;
    end

    // Set events win over a coincident clear.
    underflow_d = (underflow_q & ~flag_clr) | uf_set;
    seq_err_d   = (seq_err_q   & ~flag_clr) | seq_set;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) begin
      exp_ch_q      <= '0;
      staging_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      underflow_q   <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      exp_ch_q      <= exp_ch_d;
      staging_q     <= staging_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      underflow_q   <= underflow_d;
      seq_err_q     <= seq_err_d;
    end
  end

  // NOTE: the frame storage has no reset; a slot is only read after it has
  // been written, because count gates every pop.
  always_ff @(posedge s_axis_aud_aclk) begin
    if (push) mem_q[wr_ptr_q] <= staging_d;
  end

endmodule

// File: tb/tb_i2s_tx_10xe_aud_frame_buf.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_10xe_aud_frame_buf
//
// Table of directed vectors with hand-derived expectations, a few multi-cycle
// corner sequences (full FIFO, empty push+pop, enable drop, async reset) and
// a randomized phase. Every cycle is also compared with a queue-based frame
// model of the block.
// ---------------------------------------------------------------------------
module tb_i2s_tx_10xe_aud_frame_buf;

  localparam int NUM_CH     = 2;
  localparam int SAMPLE_W   = 24;
  localparam int SAMPLE_LSB = 4;
  localparam int DEPTH      = 4;
  localparam int FW         = NUM_CH * SAMPLE_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_en = 1'b0;
  logic          flag_clr = 1'b0;
  logic [31:0]   tdata = '0;
  logic [2:0]    tid = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          frame_req = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic          underflow_flag;
  logic          seq_err_flag;
`ifdef I2S_TX_10XE_FIFO_LEVEL_EN
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
`endif

  always #5 clk = ~clk;

  i2s_tx_10xe_aud_frame_buf #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .SAMPLE_LSB(SAMPLE_LSB), .DEPTH(DEPTH)
  ) dut (
    .s_axis_aud_aclk    (clk),
    .s_axis_aud_aresetn (rst_n),
    .core_en            (core_en),
    .flag_clr           (flag_clr),
    .s_axis_aud_tdata   (tdata),
    .s_axis_aud_tid     (tid),
    .s_axis_aud_tvalid  (tvalid),
    .s_axis_aud_tready  (tready),
    .frame_req          (frame_req),
    .frame_data         (frame_data),
    .frame_valid        (frame_valid),
    .fifo_empty         (fifo_empty),
    .fifo_full          (fifo_full),
    .underflow_flag     (underflow_flag),
    .seq_err_flag       (seq_err_flag)
`ifdef I2S_TX_10XE_FIFO_LEVEL_EN
    ,
    .fifo_level         (fifo_level)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue of complete frames ----------
  logic [FW-1:0]       m_q[$];
  int                  m_exp;
  logic [SAMPLE_W-1:0] m_stage [NUM_CH];
  logic                m_valid;
  logic [FW-1:0]       m_data;
  logic                m_uf;
  logic                m_seq;

  task automatic model_reset();
    m_q.delete();
    m_exp = 0;
    for (int k = 0; k < NUM_CH; k++) m_stage[k] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_uf    = 1'b0;
    m_seq   = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic tv,
                            input logic [2:0] t, input logic [31:0] td, input logic req);
    logic                rdy;
    logic                uf_set;
    logic                seq_set;
    logic [SAMPLE_W-1:0] s;
    logic [FW-1:0]       f;
    rdy     = en && (m_q.size() < DEPTH);
    uf_set  = 1'b0;
    seq_set = 1'b0;
    s       = td[SAMPLE_LSB +: SAMPLE_W];
    if (!en) begin
      m_q.delete();
      m_exp   = 0;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      if (req) begin
        if (m_q.size() > 0) begin
          m_data  = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_data  = '0;
          m_valid = 1'b0;
          uf_set  = 1'b1;
        end
      end else begin
        m_valid = 1'b0;
      end
      if (tv && rdy) begin
        if (int'(t) == m_exp) begin
          m_stage[m_exp] = s;
          if (m_exp == NUM_CH - 1) begin
            for (int k = 0; k < NUM_CH; k++) f[k*SAMPLE_W +: SAMPLE_W] = m_stage[k];
            m_q.push_back(f);
            m_exp = 0;
          end else begin
            m_exp++;
          end
        end else if (t == 3'd0) begin
          seq_set    = 1'b1;
          m_stage[0] = s;
          m_exp      = 1;
        end else begin
          seq_set = 1'b1;
          m_exp   = 0;
        end
      end
    end
    m_uf  = (m_uf  && !clr) || uf_set;
    m_seq = (m_seq && !clr) || seq_set;
  endtask

  // Drive one cycle, advance the model, compare just after the edge.
  task automatic cycle(input logic en, input logic clr, input logic tv,
                       input logic [2:0] t, input logic [31:0] td, input logic req);
    core_en   = en;
    flag_clr  = clr;
    tvalid    = tv;
    tid       = t;
    tdata     = td;
    frame_req = req;
    model_step(en, clr, tv, t, td, req);
    @(posedge clk);
    #1;
    check("frame_valid", frame_valid, m_valid);
    check("frame_data", frame_data, m_data);
    check("fifo_empty", fifo_empty, m_q.size() == 0);
    check("fifo_full", fifo_full, m_q.size() == DEPTH);
    check("tready", tready, en && (m_q.size() < DEPTH));
    check("underflow_flag", underflow_flag, m_uf);
    check("seq_err_flag", seq_err_flag, m_seq);
`ifdef I2S_TX_10XE_FIFO_LEVEL_EN
    check("fifo_level", fifo_level, m_q.size());
`endif
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    bit          en, clr, tv;
    bit [2:0]    tid;
    bit [31:0]   td;
    bit          req;
    bit          e_valid;
    bit [FW-1:0] e_data;
    bit          e_empty, e_full, e_uf, e_seq;
  } vec_t;

  function automatic vec_t mkv(bit en, bit clr, bit tv, bit [2:0] t, bit [31:0] td, bit req,
                               bit v, bit [FW-1:0] d, bit emp, bit full, bit uf, bit seq);
    vec_t r;
    r.en = en; r.clr = clr; r.tv = tv; r.tid = t; r.td = td; r.req = req;
    r.e_valid = v; r.e_data = d; r.e_empty = emp; r.e_full = full;
    r.e_uf = uf; r.e_seq = seq;
    return r;
  endfunction

  vec_t tbl [15];

  // Sample value v placed in the sample field of a beat.
  function automatic logic [31:0] beat(input logic [SAMPLE_W-1:0] v);
    return {{(32-SAMPLE_W-SAMPLE_LSB){1'b0}}, v, {SAMPLE_LSB{1'b0}}};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stereo frame assembly and pop.
    tbl[0]  = mkv(1'b1,1'b0,1'b1,3'd0,32'h0ABCDEF0,1'b0, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b0);
    tbl[1]  = mkv(1'b1,1'b0,1'b1,3'd1,32'h01234560,1'b0, 1'b0,48'h0,               1'b0,1'b0,1'b0,1'b0);
    tbl[2]  = mkv(1'b1,1'b0,1'b0,3'd0,32'h0,       1'b1, 1'b1,48'h123456_ABCDEF,   1'b1,1'b0,1'b0,1'b0);
    // Underflow, clear, and requests ignored while disabled.
    tbl[3]  = mkv(1'b1,1'b0,1'b0,3'd0,32'h0,       1'b1, 1'b0,48'h0,               1'b1,1'b0,1'b1,1'b0);
    tbl[4]  = mkv(1'b1,1'b1,1'b0,3'd0,32'h0,       1'b0, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b0);
    tbl[5]  = mkv(1'b0,1'b0,1'b0,3'd0,32'h0,       1'b1, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b0);
    // TID 0(A),0(B),1(C) gives frame {C,B} with a sequence error.
    tbl[6]  = mkv(1'b1,1'b0,1'b1,3'd0,32'h00000110,1'b0, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b0);
    tbl[7]  = mkv(1'b1,1'b0,1'b1,3'd0,32'h00000220,1'b0, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b1);
    tbl[8]  = mkv(1'b1,1'b0,1'b1,3'd1,32'h00000330,1'b0, 1'b0,48'h0,               1'b0,1'b0,1'b0,1'b1);
    tbl[9]  = mkv(1'b1,1'b0,1'b0,3'd0,32'h0,       1'b1, 1'b1,48'h000033_000022,   1'b1,1'b0,1'b0,1'b1);
    tbl[10] = mkv(1'b1,1'b1,1'b0,3'd0,32'h0,       1'b0, 1'b0,48'h000033_000022,   1'b1,1'b0,1'b0,1'b0);
    // Out-of-order and out-of-range TIDs are dropped; set beats clear.
    tbl[11] = mkv(1'b1,1'b0,1'b1,3'd1,32'hFFFFFFFF,1'b0, 1'b0,48'h000033_000022,   1'b1,1'b0,1'b0,1'b1);
    tbl[12] = mkv(1'b1,1'b1,1'b1,3'd5,32'h0,       1'b0, 1'b0,48'h000033_000022,   1'b1,1'b0,1'b0,1'b1);
    tbl[13] = mkv(1'b1,1'b0,1'b1,3'd0,32'h0,       1'b0, 1'b0,48'h000033_000022,   1'b1,1'b0,1'b0,1'b1);
    tbl[14] = mkv(1'b0,1'b0,1'b0,3'd0,32'h0,       1'b1, 1'b0,48'h0,               1'b1,1'b0,1'b0,1'b1);

    // ---------------- reset values ----------------
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst frame_valid", frame_valid, 1'b0);
    check("rst frame_data", frame_data, '0);
    check("rst fifo_empty", fifo_empty, 1'b1);
    check("rst fifo_full", fifo_full, 1'b0);
    check("rst tready", tready, 1'b0);
    check("rst underflow", underflow_flag, 1'b0);
    check("rst seq_err", seq_err_flag, 1'b0);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].en, tbl[i].clr, tbl[i].tv, tbl[i].tid, tbl[i].td, tbl[i].req);
      check($sformatf("tbl%0d valid", i), frame_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d data", i), frame_data, tbl[i].e_data);
      check($sformatf("tbl%0d empty", i), fifo_empty, tbl[i].e_empty);
      check($sformatf("tbl%0d full", i), fifo_full, tbl[i].e_full);
      check($sformatf("tbl%0d uf", i), underflow_flag, tbl[i].e_uf);
      check($sformatf("tbl%0d seq", i), seq_err_flag, tbl[i].e_seq);
    end

    // ---------------- fill to DEPTH, then one pop ----------------
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
    for (int f = 0; f < DEPTH; f++) begin
      cycle(1'b1, 1'b0, 1'b1, 3'd0, beat(24'h100 + 24'(f)), 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 3'd1, beat(24'h200 + 24'(f)), 1'b0);
    end
    check("full fifo_full", fifo_full, 1'b1);
    check("full tready", tready, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd0, beat(24'h777), 1'b1);
    check("pop tready", tready, 1'b1);
    check("pop valid", frame_valid, 1'b1);
    check("pop data", frame_data, 48'h000200_000100);
    // Drain and check order.
    for (int f = 1; f < DEPTH; f++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
      check("drain data", frame_data, {24'h200 + 24'(f), 24'h100 + 24'(f)});
    end

    // ---------------- push and pop together on empty FIFO ----------------
    cycle(1'b1, 1'b1, 1'b1, 3'd0, beat(24'hA0A0A0), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd1, beat(24'hB0B0B0), 1'b1);
    check("nobypass valid", frame_valid, 1'b0);
    check("nobypass uf", underflow_flag, 1'b1);
    check("nobypass empty", fifo_empty, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    check("nobypass pop", frame_data, 48'hB0B0B0_A0A0A0);

    // ---------------- enable drop mid-frame ----------------
    cycle(1'b1, 1'b1, 1'b1, 3'd0, beat(24'h111111), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd1, beat(24'h222222), 1'b0);
    check("endrop seq", seq_err_flag, 1'b1);
    check("endrop empty", fifo_empty, 1'b1);

    // ---------------- async reset mid-frame ----------------
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 3'd0, beat(24'h333333), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd1, beat(24'h444444), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd0, beat(24'h555555), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst frame_valid", frame_valid, 1'b0);
    check("arst frame_data", frame_data, '0);
    check("arst fifo_empty", fifo_empty, 1'b1);
    check("arst fifo_full", fifo_full, 1'b0);
    check("arst underflow", underflow_flag, 1'b0);
    check("arst seq_err", seq_err_flag, 1'b0);
    core_en = 1'b0;
    #1;
    check("arst tready", tready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    // Expected channel is back at 0, so a TID 1 beat is an order error.
    cycle(1'b1, 1'b0, 1'b1, 3'd1, beat(24'h666666), 1'b0);
    check("post-rst seq", seq_err_flag, 1'b1);

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 1500; i++) begin
      logic       en, clr, tv, req;
      logic [2:0] t;
      en  = ($urandom_range(0, 39) != 0);
      clr = ($urandom_range(0, 29) == 0);
      tv  = ($urandom_range(0, 9) < 7);
      t   = ($urandom_range(0, 9) < 8) ? 3'(m_exp) : 3'($urandom_range(0, 7));
      req = ($urandom_range(0, 9) < (((i / 200) % 2 == 0) ? 2 : 5));
      cycle(en, clr, tv, t, $urandom, req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
